rotary_param_ctrl: RTL and testbench

ROTARY_PARAM_CTRL -- requirements
Module: rotary_param_ctrl

---
 rtl/rotary_pkg.sv | 15 +
 rtl/rotary_param_ctrl_press_timer.sv | 28 ++
 rtl/rotary_param_ctrl.sv | 118 +++++++++++
 tb/tb_rotary_param_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rotary_pkg.sv
// rtl/rotary_pkg.sv - shared state encoding and default constants for rotary_param_ctrl
package rotary_pkg;

  typedef enum logic [2:0] {
    BROWSE   = 3'd0,
    B_PRESS  = 3'd1,
    EDIT     = 3'd2,
    E_PRESS  = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  localparam logic [7:0]  DEFAULT_VAL  = 8'h80;
  localparam logic [23:0] LONG_CYC_DEF = 24'd5_000_000;

endpackage

// File: rtl/rotary_param_ctrl_press_timer.sv
// rtl/rotary_param_ctrl_press_timer.sv - saturating button-hold counter with long-press flag
module press_timer #(
  parameter int            CW    = 24,
  parameter logic [CW-1:0] LIMIT = CW'(1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic reached
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // Asserted in the cycle whose increment lands on LIMIT, so the owner can act on that same edge.
  assign reached = en && !clr && (count >= (LIMIT - 1'b1));

endmodule

// File: rtl/rotary_param_ctrl.sv
// rtl/rotary_param_ctrl.sv - rotary encoder + button parameter browse/edit controller
module rotary_param_ctrl
  import rotary_pkg::*;
#(
  parameter int          NPARAM   = 4,
  parameter int          W        = 8,
  parameter logic [W-1:0] DEFAULT = W'(DEFAULT_VAL),
  parameter logic [23:0] LONG_CYC = LONG_CYC_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rotary_moved,
  input  logic                      rotary_dir,
  input  logic                      btn,
  output logic [$clog2(NPARAM)-1:0] sel,
  output logic                      edit,
  output logic [NPARAM*W-1:0]       param_bus,
  output logic                      upd
);

  localparam int             SW      = $clog2(NPARAM);
  localparam logic [SW-1:0]  SEL_MAX = SW'(NPARAM - 1);
  localparam logic [W-1:0]   VAL_MAX = '1;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_d;
  logic [W-1:0]  prm [NPARAM];
  logic [W-1:0]  cur, wr_val;
  logic          wr, tmr_clr, tmr_en, long_hit;
  logic          btn_q, primed, btn_rise;

  // primed masks the first cycle after reset so a button already held is not seen as a press.
  assign btn_rise = primed & btn & ~btn_q;
  assign tmr_en   = btn & ((state_q == B_PRESS) || (state_q == E_PRESS));
  assign cur      = prm[sel];

  press_timer #(
    .CW    (24),
    .LIMIT (LONG_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .reached (long_hit)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    wr      = 1'b0;
    wr_val  = cur;
    tmr_clr = 1'b0;
    case (state_q)
      BROWSE: begin
        if (btn_rise) begin
          state_d = B_PRESS;
          tmr_clr = 1'b1;
        end else if (rotary_moved) begin
          if (rotary_dir) sel_d = (sel == SEL_MAX) ? '0 : sel + 1'b1;
          else            sel_d = (sel == '0) ? SEL_MAX : sel - 1'b1;
        end
      end
      EDIT: begin
        if (btn_rise) begin
          state_d = E_PRESS;
          tmr_clr = 1'b1;
        end else if (rotary_moved) begin
          if (rotary_dir && (cur != VAL_MAX)) begin
            wr     = 1'b1;
            wr_val = cur + 1'b1;
          end else if (!rotary_dir && (cur != '0)) begin
            wr     = 1'b1;
            wr_val = cur - 1'b1;
          end
        end
      end
      B_PRESS, E_PRESS: begin
        if (!btn) begin
          state_d = (state_q == B_PRESS) ? EDIT : BROWSE;
        end else if (long_hit) begin
          wr      = 1'b1;
          wr_val  = DEFAULT;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!btn) state_d = BROWSE;
      end
      default: state_d = BROWSE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BROWSE;
      sel     <= '0;
      edit    <= 1'b0;
      upd     <= 1'b0;
      btn_q   <= 1'b0;
      primed  <= 1'b0;
      for (int k = 0; k < NPARAM; k++) prm[k] <= DEFAULT;
    end else begin
      state_q <= state_d;
      sel     <= sel_d;
      edit    <= (state_d == EDIT) || (state_d == E_PRESS);
      upd     <= wr;
      btn_q   <= btn;
      primed  <= 1'b1;
      if (wr) prm[sel] <= wr_val;
    end
  end

  for (genvar k = 0; k < NPARAM; k++) begin : g_bus
    assign param_bus[k*W +: W] = prm[k];
  end

endmodule

// File: tb/tb_rotary_param_ctrl.sv
// tb/tb_rotary_param_ctrl.sv - table, directed and randomized checks for rotary_param_ctrl
module tb_rotary_param_ctrl;

  localparam int NP = 4;
  localparam int LC = 10;
  localparam int MB = 0, MBP = 1, ME = 2, MEP = 3, MW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rotary_moved = 1'b0;
  logic        rotary_dir = 1'b0;
  logic        btn = 1'b0;
  logic [1:0]  sel;
  logic        edit;
  logic [31:0] param_bus;
  logic        upd;

  int checks = 0;
  int errors = 0;

  rotary_param_ctrl #(
    .NPARAM   (NP),
    .W        (8),
    .DEFAULT  (8'h80),
    .LONG_CYC (24'(LC))
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rotary_moved (rotary_moved),
    .rotary_dir   (rotary_dir),
    .btn          (btn),
    .sel          (sel),
    .edit         (edit),
    .param_bus    (param_bus),
    .upd          (upd)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  typedef struct {
    logic       mv;
    logic       dir;
    logic       b;
    int         sel;
    logic       ed;
    logic       up;
    logic [7:0] val;
  } vec_t;

  vec_t tbl[$];

  int  m_sel, m_mode, m_hold;
  int  m_par[NP];
  bit  m_prev, m_armed, m_upd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic m, input logic d, input logic b);
    @(negedge clk);
    rotary_moved = m;
    rotary_dir   = d;
    btn          = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pval(input int k);
    return param_bus[k*8 +: 8];
  endfunction

  function automatic vec_t mk(input logic mv, input logic dir, input logic b, input int s,
                              input logic ed, input logic up, input logic [7:0] val);
    vec_t v;
    v.mv = mv; v.dir = dir; v.b = b; v.sel = s; v.ed = ed; v.up = up; v.val = val;
    return v;
  endfunction

  task automatic model_reset();
    m_sel = 0; m_mode = MB; m_hold = 0; m_prev = 0; m_armed = 0; m_upd = 0;
    for (int k = 0; k < NP; k++) m_par[k] = 128;
  endtask

  task automatic model_step(input bit mv, input bit dir, input bit b);
    bit rise;
    int nv;
    rise  = m_armed && b && !m_prev;
    m_upd = 0;
    case (m_mode)
      MB: begin
        if (rise) begin m_mode = MBP; m_hold = 0; end
        else if (mv) m_sel = dir ? (m_sel + 1) % NP : (m_sel + NP - 1) % NP;
      end
      ME: begin
        if (rise) begin m_mode = MEP; m_hold = 0; end
        else if (mv) begin
          nv = m_par[m_sel] + (dir ? 1 : -1);
          if (nv > 255) nv = 255;
          if (nv < 0) nv = 0;
          if (nv != m_par[m_sel]) begin m_par[m_sel] = nv; m_upd = 1; end
        end
      end
      MBP, MEP: begin
        if (!b) m_mode = (m_mode == MBP) ? ME : MB;
        else begin
          m_hold++;
          if (m_hold == LC) begin m_par[m_sel] = 128; m_upd = 1; m_mode = MW; end
        end
      end
      default: if (!b) m_mode = MB;
    endcase
    m_prev  = b;
    m_armed = 1;
  endtask

  function automatic logic [31:0] model_bus();
    logic [31:0] r;
    for (int k = 0; k < NP; k++) r[k*8 +: 8] = 8'(m_par[k]);
    return r;
  endfunction

  initial begin
    int  n;
    bit  rb;
    bit  rm, rd;

    // Down-wrap browse, short-press edit, back-to-back detents, button-wins collision.
    tbl.push_back(mk(1,0,0, 3,0,0,8'h80));
    tbl.push_back(mk(1,0,0, 2,0,0,8'h80));
    tbl.push_back(mk(1,0,0, 1,0,0,8'h80));
    tbl.push_back(mk(1,0,0, 0,0,0,8'h80));
    tbl.push_back(mk(1,0,0, 3,0,0,8'h80));
    tbl.push_back(mk(0,0,0, 3,0,0,8'h80));
    tbl.push_back(mk(0,0,1, 3,0,0,8'h80));
    tbl.push_back(mk(0,0,0, 3,1,0,8'h80));
    tbl.push_back(mk(1,1,0, 3,1,1,8'h81));
    tbl.push_back(mk(0,0,0, 3,1,0,8'h81));
    tbl.push_back(mk(1,1,0, 3,1,1,8'h82));
    tbl.push_back(mk(1,1,0, 3,1,1,8'h83));
    tbl.push_back(mk(0,0,0, 3,1,0,8'h83));
    tbl.push_back(mk(0,0,1, 3,1,0,8'h83));
    tbl.push_back(mk(1,1,1, 3,1,0,8'h83));
    tbl.push_back(mk(0,0,0, 3,0,0,8'h83));
    tbl.push_back(mk(1,1,1, 3,0,0,8'h83));
    tbl.push_back(mk(1,0,1, 3,0,0,8'h83));
    tbl.push_back(mk(0,0,0, 3,1,0,8'h83));
    tbl.push_back(mk(1,0,0, 3,1,1,8'h82));
    tbl.push_back(mk(0,0,1, 3,1,0,8'h82));
    tbl.push_back(mk(0,0,0, 3,0,0,8'h82));

    #12;
    chk("reset_sel", sel, 0);
    chk("reset_edit", edit, 0);
    chk("reset_upd", upd, 0);
    chk("reset_bus", param_bus, 32'h80808080);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].mv, tbl[i].dir, tbl[i].b);
      chk($sformatf("tbl%0d_sel", i), sel, tbl[i].sel);
      chk($sformatf("tbl%0d_edit", i), edit, tbl[i].ed);
      chk($sformatf("tbl%0d_upd", i), upd, tbl[i].up);
      chk($sformatf("tbl%0d_val", i), pval(tbl[i].sel), tbl[i].val);
    end

    // Upper saturation: only the detent that reaches 0xFF pulses upd.
    step(0,0,1); step(0,0,0);
    repeat (124) step(1,1,0);
    chk("sat_pre", pval(3), 8'hFE);
    n = 0;
    repeat (3) begin step(1,1,0); n += int'(upd); end
    step(0,0,0); n += int'(upd);
    chk("sat_upd_count", n, 1);
    chk("sat_val", pval(3), 8'hFF);
    step(0,0,1); step(0,0,0);

    // Long press on param 2 with LONG_CYC = 10.
    step(1,0,0);
    chk("lp_sel", sel, 2);
    step(0,0,1); step(0,0,0);
    repeat (112) step(1,0,0);
    step(0,0,1); step(0,0,0);
    chk("lp_pre_edit", edit, 0);
    chk("lp_pre_val", pval(2), 8'h10);
    step(0,0,1);
    for (int j = 1; j <= 14; j++) begin
      step(0,0,1);
      chk($sformatf("lp%0d_val", j), pval(2), (j >= 10) ? 8'h80 : 8'h10);
      chk($sformatf("lp%0d_upd", j), upd, (j == 10));
    end
    chk("lp_hold_edit", edit, 0);
    step(0,0,0);
    chk("lp_rel_edit", edit, 0);
    step(1,1,0);
    chk("lp_browse_sel", sel, 3);

    // Asynchronous reset during E_PRESS, button still held across release.
    step(0,0,1); step(0,0,0);
    step(0,0,1);
    chk("rst_pre_edit", edit, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", sel, 0);
    chk("arst_edit", edit, 0);
    chk("arst_upd", upd, 0);
    chk("arst_bus", param_bus, 32'h80808080);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (2) begin step(0,0,1); n += int'(upd) + int'(edit); end
    step(0,0,0); n += int'(upd) + int'(edit);
    chk("arst_quiet", n, 0);
    step(1,1,0);
    chk("arst_browse_sel", sel, 1);
    chk("arst_browse_edit", edit, 0);

    // Randomized run against the behavioural model.
    @(negedge clk);
    rst_n = 1'b0; btn = 1'b0; rotary_moved = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_step(0,0,0);
    rb = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0,7) == 0) rb = !rb;
      rm = 1'($urandom_range(0,1));
      rd = 1'($urandom_range(0,1));
      step(rm, rd, rb);
      model_step(rm, rd, rb);
      chk($sformatf("rnd%0d_sel", c), sel, m_sel);
      chk($sformatf("rnd%0d_edit", c), edit, (m_mode == ME) || (m_mode == MEP));
      chk($sformatf("rnd%0d_upd", c), upd, m_upd);
      chk($sformatf("rnd%0d_bus", c), param_bus, model_bus());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
